// File: rtl/toggle_energy_meter.sv
// Counts 0->1 transitions on monitored gate outputs: saturating lifetime count per line
// plus per-window transition/energy totals delivered over a valid/ready report port.

module tem_line_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                        cnt_d = '0;
    else if (inc && (cnt_q != '1))    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

module toggle_energy_meter #(
  parameter int N_LINES     = 4,
  parameter int CNT_W       = 16,
  parameter int E_PER_TRANS = 1,
  parameter int E_W         = 24,
  parameter int WINDOW      = 256,
  localparam int SEL_W      = (N_LINES > 1) ? $clog2(N_LINES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [N_LINES-1:0] sense,
  input  logic               clear,
  input  logic [SEL_W-1:0]   sel_line,
  output logic [CNT_W-1:0]   sel_count,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [CNT_W-1:0]   rpt_trans,
  output logic [E_W-1:0]     rpt_energy,
  output logic               rpt_overrun
);
  localparam int PW    = $clog2(N_LINES + 1);
  localparam int WIN_W = $clog2(WINDOW);
  localparam int EXW   = E_W + 32;

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  state_t             state_q, state_d;
  logic [N_LINES-1:0] prev_q, prev_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]   win_trans_q, win_trans_d;
  logic [E_W-1:0]     win_energy_q, win_energy_d;
  logic               rpt_valid_q, rpt_valid_d;
  logic [CNT_W-1:0]   rpt_trans_q, rpt_trans_d;
  logic [E_W-1:0]     rpt_energy_q, rpt_energy_d;
  logic               rpt_overrun_q, rpt_overrun_d;

  logic [N_LINES-1:0]            rise;
  logic [PW-1:0]                 pop;
  logic                          meas, win_last, accept;
  logic [CNT_W:0]                t_sum;
  logic [CNT_W-1:0]              t_sat;
  logic [EXW-1:0]                e_sum;
  logic [E_W-1:0]                e_sat;
  logic [N_LINES-1:0][CNT_W-1:0] life;

  assign meas     = (state_q == MEASURE) && enable;
  assign win_last = meas && (win_cnt_q == WIN_W'(WINDOW - 1));
  assign accept   = rpt_valid_q && rpt_ready;
  assign rise     = sense & ~prev_q;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_LINES; i++) pop = pop + PW'(rise[i]);
  end

  // Sums including this cycle's rises, saturated; feed both the accumulators and the report.
  always_comb begin
    t_sum = {1'b0, win_trans_q} + (CNT_W+1)'(pop);
    t_sat = t_sum[CNT_W] ? '1 : t_sum[CNT_W-1:0];
    e_sum = EXW'(win_energy_q) + EXW'(pop) * EXW'(E_PER_TRANS);
    e_sat = (|e_sum[EXW-1:E_W]) ? '1 : e_sum[E_W-1:0];
  end

  genvar g;
  generate
    for (g = 0; g < N_LINES; g++) begin : g_line
      tem_line_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk  (clk),
        .reset(reset),
        .clear(clear),
        .inc  (meas & rise[g]),
        .cnt  (life[g])
      );
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    win_cnt_d    = win_cnt_q;
    win_trans_d  = win_trans_q;
    win_energy_d = win_energy_q;
    case (state_q)
      IDLE: if (enable) state_d = ARM;
      ARM: begin
        prev_d       = sense;
        win_cnt_d    = '0;
        win_trans_d  = '0;
        win_energy_d = '0;
        state_d      = enable ? MEASURE : IDLE;
      end
      MEASURE: begin
        if (!enable) begin
          state_d      = IDLE;
          win_cnt_d    = '0;
          win_trans_d  = '0;
          win_energy_d = '0;
        end else begin
          prev_d = sense;
          if (win_last) begin
            win_cnt_d    = '0;
            win_trans_d  = '0;
            win_energy_d = '0;
          end else begin
            win_cnt_d    = win_cnt_q + 1'b1;
            win_trans_d  = t_sat;
            win_energy_d = e_sat;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A finished window loads only if the slot is free or being freed this edge.
  always_comb begin
    rpt_valid_d   = rpt_valid_q;
    rpt_trans_d   = rpt_trans_q;
    rpt_energy_d  = rpt_energy_q;
    rpt_overrun_d = rpt_overrun_q;
    if (accept) rpt_valid_d = 1'b0;
    if (win_last) begin
      if (!rpt_valid_q || accept) begin
        rpt_valid_d  = 1'b1;
        rpt_trans_d  = t_sat;
        rpt_energy_d = e_sat;
      end else begin
        rpt_overrun_d = 1'b1;
      end
    end
    if (clear) rpt_overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      prev_q        <= '0;
      win_cnt_q     <= '0;
      win_trans_q   <= '0;
      win_energy_q  <= '0;
      rpt_valid_q   <= 1'b0;
      rpt_trans_q   <= '0;
      rpt_energy_q  <= '0;
      rpt_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      win_cnt_q     <= win_cnt_d;
      win_trans_q   <= win_trans_d;
      win_energy_q  <= win_energy_d;
      rpt_valid_q   <= rpt_valid_d;
      rpt_trans_q   <= rpt_trans_d;
      rpt_energy_q  <= rpt_energy_d;
      rpt_overrun_q <= rpt_overrun_d;
    end
  end

  always_comb begin
    sel_count = '0;
    for (int i = 0; i < N_LINES; i++)
      if (SEL_W'(i) == sel_line) sel_count = life[i];
  end

  assign rpt_valid   = rpt_valid_q;
  assign rpt_trans   = rpt_trans_q;
  assign rpt_energy  = rpt_energy_q;
  assign rpt_overrun = rpt_overrun_q;
endmodule

// File: tb/tb_toggle_energy_meter.sv
// Bench for toggle_energy_meter: window table with scoreboard, plus overrun, same-edge
// accept, and a narrow-counter instance for saturation and mid-window reset.

module tb_toggle_energy_meter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: CNT_W=16
  logic        reset, enable, clear, rpt_ready;
  logic [3:0]  sense;
  logic [1:0]  sel_line;
  logic [15:0] sel_count, rpt_trans;
  logic [23:0] rpt_energy;
  logic        rpt_valid, rpt_overrun;

  toggle_energy_meter #(.N_LINES(4), .CNT_W(16), .E_PER_TRANS(3), .E_W(24), .WINDOW(8)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .sense(sense), .clear(clear),
    .sel_line(sel_line), .sel_count(sel_count), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_trans(rpt_trans), .rpt_energy(rpt_energy), .rpt_overrun(rpt_overrun)
  );

  // Instance B: CNT_W=4
  logic        reset_b, enable_b, clear_b, rpt_ready_b;
  logic [3:0]  sense_b;
  logic [1:0]  sel_line_b;
  logic [3:0]  sel_count_b, rpt_trans_b;
  logic [23:0] rpt_energy_b;
  logic        rpt_valid_b, rpt_overrun_b;

  toggle_energy_meter #(.N_LINES(4), .CNT_W(4), .E_PER_TRANS(3), .E_W(24), .WINDOW(8)) dut_b (
    .clk(clk), .reset(reset_b), .enable(enable_b), .sense(sense_b), .clear(clear_b),
    .sel_line(sel_line_b), .sel_count(sel_count_b), .rpt_valid(rpt_valid_b),
    .rpt_ready(rpt_ready_b), .rpt_trans(rpt_trans_b), .rpt_energy(rpt_energy_b),
    .rpt_overrun(rpt_overrun_b)
  );

  typedef struct {
    logic [3:0]  arm;
    logic [31:0] pat;   // nibble i = sense on MEASURE cycle i
    int          trans;
    int          energy;
  } vec_t;

  typedef struct { int t; int e; } rpt_t;

  vec_t tbl [4];
  rpt_t sb [$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [3:0] arm);
    enable = 1'b1;
    sense  = arm;
    tick();
    tick();
  endtask

  task automatic meas(input logic [31:0] pat);
    for (int i = 0; i < 8; i++) begin
      sense = pat[4*i +: 4];
      tick();
    end
  endtask

  task automatic stop();
    enable = 1'b0;
    tick();
  endtask

  task automatic accept_rpt(input string nm);
    rpt_t r;
    chk({nm, "_valid"}, int'(rpt_valid), 1);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_sb actual=empty required=entry", nm);
    end else begin
      r = sb.pop_front();
      chk({nm, "_trans"}, int'(rpt_trans), r.t);
      chk({nm, "_energy"}, int'(rpt_energy), r.e);
    end
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;
  endtask

  initial begin
    int exp_life [4];
    logic [3:0] prev, cur;

    tbl[0] = '{arm: 4'h0, pat: 32'hF0F0F0F0, trans: 16, energy: 48};
    tbl[1] = '{arm: 4'h5, pat: 32'h55555555, trans: 0,  energy: 0};
    tbl[2] = '{arm: 4'h0, pat: 32'h84218421, trans: 8,  energy: 24};
    tbl[3] = '{arm: 4'hF, pat: 32'hF0C30FF0, trans: 12, energy: 36};

    reset = 1'b1; enable = 1'b0; clear = 1'b0; rpt_ready = 1'b0; sense = 4'h0; sel_line = 2'd0;
    reset_b = 1'b1; enable_b = 1'b0; clear_b = 1'b0; rpt_ready_b = 1'b1; sense_b = 4'h0;
    sel_line_b = 2'd0;
    tick(); tick();

    // Reset state, then idle with all lines high
    reset = 1'b0;
    sense = 4'hF;
    repeat (5) tick();
    chk("rst_valid", int'(rpt_valid), 0);
    chk("rst_overrun", int'(rpt_overrun), 0);
    for (int l = 0; l < 4; l++) begin
      sel_line = 2'(l);
      #1;
      chk($sformatf("rst_life%0d", l), int'(sel_count), 0);
    end

    // Table of single windows
    for (int v = 0; v < 4; v++) begin
      clear = 1'b1; tick(); clear = 1'b0;
      prev = tbl[v].arm;
      for (int l = 0; l < 4; l++) exp_life[l] = 0;
      for (int i = 0; i < 8; i++) begin
        cur = tbl[v].pat[4*i +: 4];
        for (int l = 0; l < 4; l++) if (cur[l] && !prev[l]) exp_life[l]++;
        prev = cur;
      end
      sense = tbl[v].arm;
      tick();
      start(tbl[v].arm);
      sb.push_back('{t: tbl[v].trans, e: tbl[v].energy});
      meas(tbl[v].pat);
      stop();
      for (int l = 0; l < 4; l++) begin
        sel_line = 2'(l);
        #1;
        chk($sformatf("v%0d_life%0d", v, l), int'(sel_count), exp_life[l]);
      end
      accept_rpt($sformatf("v%0d", v));
      chk($sformatf("v%0d_drop", v), int'(rpt_valid), 0);
    end

    // Two window ends with no consumer: second result dropped, overrun set
    clear = 1'b1; tick(); clear = 1'b0;
    start(4'h0);
    sb.push_back('{t: 16, e: 48});
    meas(32'hF0F0F0F0);
    meas(32'hFFFFFFF0);
    chk("ovr_flag", int'(rpt_overrun), 1);
    stop();
    chk("ovr_hold_idle", int'(rpt_valid), 1);
    accept_rpt("ovr");
    chk("ovr_drop", int'(rpt_valid), 0);
    chk("ovr_sticky", int'(rpt_overrun), 1);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("ovr_clear", int'(rpt_overrun), 0);

    // Pending report accepted on the exact window-end edge
    start(4'h0);
    sb.push_back('{t: 16, e: 48});
    meas(32'hF0F0F0F0);
    sb.push_back('{t: 7, e: 21});
    for (int i = 0; i < 7; i++) begin
      sense = 32'h84218421 >> (4*i);
      tick();
    end
    sense = 4'h8;
    rpt_ready = 1'b1;
    begin
      rpt_t r;
      r = sb.pop_front();
      chk("edge_old_trans", int'(rpt_trans), r.t);
      chk("edge_old_energy", int'(rpt_energy), r.e);
    end
    tick();
    rpt_ready = 1'b0;
    chk("edge_valid", int'(rpt_valid), 1);
    chk("edge_overrun", int'(rpt_overrun), 0);
    stop();
    accept_rpt("edge_new");

    // Narrow counters: saturation, then mid-window reset
    reset_b = 1'b0;
    enable_b = 1'b1;
    sense_b = 4'h0;
    tick(); tick();
    for (int i = 0; i < 40; i++) begin
      sense_b = (i % 2 == 0) ? 4'h1 : 4'h0;
      tick();
    end
    sel_line_b = 2'd0;
    #1;
    chk("sat_life0", int'(sel_count_b), 15);
    sense_b = 4'h1;
    repeat (3) tick();
    chk("sat_hold", int'(sel_count_b), 15);
    sense_b = 4'h0;
    tick();
    reset_b = 1'b1;
    tick();
    chk("mrst_valid", int'(rpt_valid_b), 0);
    chk("mrst_trans", int'(rpt_trans_b), 0);
    chk("mrst_energy", int'(rpt_energy_b), 0);
    chk("mrst_overrun", int'(rpt_overrun_b), 0);
    chk("mrst_life0", int'(sel_count_b), 0);
    reset_b = 1'b0;
    enable_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sense_b = (i % 2 == 0) ? 4'h1 : 4'h0;
      tick();
    end
    chk("mrst_idle_life0", int'(sel_count_b), 0);
    enable_b = 1'b1;
    sense_b = 4'h0;
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      sense_b = (i == 0 || i == 2) ? 4'h1 : 4'h0;
      tick();
    end
    chk("post_valid", int'(rpt_valid_b), 1);
    chk("post_trans", int'(rpt_trans_b), 2);
    chk("post_energy", int'(rpt_energy_b), 6);
    chk("post_life0", int'(sel_count_b), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/toggle_energy_meter.md
Name: toggle_energy_meter

Overview:
- Downstream consumer of the gate-level models (NOR/NAND/INV stages); the gate outputs drive its `sense` lines.
- Samples up to N_LINES gate outputs on every clock and detects 0->1 transitions, which are the energy-consuming events.
- Keeps a saturating lifetime transition count per line.
- Over fixed windows of WINDOW cycles, accumulates total transitions and energy units, and delivers each window's totals through a valid/ready report port.

Parameters:
- N_LINES, 4, number of monitored gate outputs (1..8)
- CNT_W, 16, width of per-line and per-window transition counters
- E_PER_TRANS, 1, energy units charged per 0->1 transition
- E_W, 24, width of the energy accumulator
- WINDOW, 256, measurement window length in clock cycles (>=2)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  measurement enable
- sense  in  N_LINES  sampled gate outputs, one per bit
- clear  in  1  synchronous clear of lifetime counters and overrun flag
- sel_line  in  clog2(N_LINES) (min 1)  line index for lifetime readout
- sel_count  out  CNT_W  lifetime 0->1 count of line sel_line, combinational mux of registers
- rpt_valid  out  1  window report available
- rpt_ready  in  1  consumer accepts report
- rpt_trans  out  CNT_W  total transitions in reported window
- rpt_energy  out  E_W  energy units in reported window
- rpt_overrun  out  1  sticky: at least one window report was dropped

Behaviour:
- Reset (sync, highest priority):
  - State goes to IDLE.
  - prev, the window counter, the window accumulators, the lifetime counters, rpt_valid, rpt_trans, rpt_energy and rpt_overrun all become 0.
  - sel_count reads 0.
- States:
  - IDLE: no counting. enable=1 -> ARM.
  - ARM: one cycle. prev <= sense, so levels already high at start are not counted. Window counter <= 0. -> MEASURE. enable=0 -> IDLE.
  - MEASURE:
    - rise = sense & ~prev; prev <= sense every cycle.
    - Per line, lifetime[i] += rise[i]; saturates at 2^CNT_W-1.
    - win_trans += popcount(rise); saturates at 2^CNT_W-1.
    - win_energy += popcount(rise)*E_PER_TRANS; saturates at 2^E_W-1.
    - Window counter counts 0..WINDOW-1.
    - enable=0 -> IDLE: window accumulators cleared, partial window discarded, no report.
- Window end, on the MEASURE cycle where the window counter = WINDOW-1:
  - Totals including that cycle's rises are the window result.
  - Next cycle: accumulators restart at 0 and the window counter at 0. Measurement is continuous, with no dead cycle.
  - Report latency: rpt_valid rises the cycle after the last window cycle.
- Report handshake:
  - Transfer occurs on a cycle with rpt_valid & rpt_ready.
  - rpt_trans and rpt_energy stay stable while rpt_valid=1 and not accepted.
  - rpt_valid falls the cycle after acceptance, unless a new result loads that same edge.
- Window end while a report is pending:
  - If the pending report is accepted on that same edge: the new result loads, rpt_valid stays 1, no overrun.
  - Otherwise: the old report is kept, the new result is dropped, and rpt_overrun <= 1.
- clear:
  - Zeroes all lifetime counters and rpt_overrun.
  - Does not touch the window accumulators, state, or the pending report.
  - If a rise and clear occur on the same cycle, clear wins and the counter becomes 0.
- enable:
  - Deasserting enable never drops a pending report. The consumer can still accept it in IDLE.
  - Re-enabling always passes through ARM.

Test Plan (N_LINES=4, WINDOW=8, E_PER_TRANS=3, CNT_W=16, E_W=24 unless noted):
- Reset applied, then released with enable=0 and sense=4'b1111 for 5 cycles -> rpt_valid=0, rpt_overrun=0, sel_count=0 for all lines, no counting.
- sense=0 at ARM, then 8 MEASURE cycles alternating 0000/1111, starting with 0000 -> rises on cycles 1,3,5,7. Required: rpt_valid=1 the next cycle, rpt_trans=16, rpt_energy=48, each line's lifetime count=4.
- sense=4'b0101 held from before enable through a full window -> rpt_trans=0, rpt_energy=0, lifetime counts 0. Confirms ARM pre-load.
- rpt_ready=0 across two window ends with window 1 = 16 transitions and window 2 = 4 transitions -> report holds 16/48, rpt_overrun=1. Then rpt_ready=1 for 1 cycle -> rpt_valid=0 next cycle. Then clear -> rpt_overrun=0.
- Pending report accepted on the exact window-end edge -> rpt_valid stays 1, new totals load, rpt_overrun=0.
- CNT_W=4, line 0 toggling for 20 rises -> sel_count(sel_line=0)=15, holding. Then reset asserted mid-window -> next cycle all outputs 0, state IDLE, and the next report after re-enable contains only post-reset rises.
